// File: rtl/nx_fifo_param_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | nx_fifo_param_if                                                            |
// | Producer/consumer bus of nx_fifo_param: requests in, data and status out.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface nx_fifo_param_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              clear_i;
    logic              wen_i;
    logic [DATA_W-1:0] wdata_i;
    logic              ren_i;
    logic [DATA_W-1:0] rdata_o;
    logic              rvalid_o;
    logic              empty_o;
    logic              full_o;
    logic              almost_empty_o;
    logic              almost_full_o;
    logic [CW-1:0]     used_slots_o;
    logic [CW-1:0]     free_slots_o;
    logic [CW-1:0]     hwm_o;
    logic              overflow_o;
    logic              underflow_o;

    modport master (
        output clear_i, wen_i, wdata_i, ren_i,
        input  rdata_o, rvalid_o, empty_o, full_o, almost_empty_o, almost_full_o,
        input  used_slots_o, free_slots_o, hwm_o, overflow_o, underflow_o
    );

    modport slave (
        input  clear_i, wen_i, wdata_i, ren_i,
        output rdata_o, rvalid_o, empty_o, full_o, almost_empty_o, almost_full_o,
        output used_slots_o, free_slots_o, hwm_o, overflow_o, underflow_o
    );
endinterface
`default_nettype wire

// File: rtl/nx_fifo_param.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | nx_fifo_param                                                               |
// | Parametrised single-clock FIFO with show-ahead or registered read port,     |
// | almost-full/almost-empty thresholds and a high-water-mark monitor.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module nx_fifo_param #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 0,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    nx_fifo_param_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [CW-1:0] c_af    = CW'(AF_THRESH);
    localparam logic [CW-1:0] c_ae    = CW'(AE_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [CW-1:0]     hwm_q;
    logic [CW-1:0]     hwm_d;
    logic              overflow_q;
    logic              underflow_q;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    // Acceptance looks only at the registered count, never at same-cycle requests
    assign w_full  = (count_q == c_depth);
    assign w_empty = (count_q == '0);
    assign w_wr    = bus.wen_i & ~w_full  & ~bus.clear_i;
    assign w_rd    = bus.ren_i & ~w_empty & ~bus.clear_i;

    always_comb begin
        count_d = count_q;
        if (bus.clear_i) begin
            count_d = '0;
        end else if (w_wr && !w_rd) begin
            count_d = count_q + CW'(1);
        end else if (w_rd && !w_wr) begin
            count_d = count_q - CW'(1);
        end
        hwm_d = '0;
        if (!bus.clear_i) begin
            hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            hwm_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            hwm_q       <= hwm_d;
            overflow_q  <= bus.wen_i & w_full  & ~bus.clear_i;
            underflow_q <= bus.ren_i & w_empty & ~bus.clear_i;
            if (bus.clear_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (w_wr) wptr_q <= wptr_q + AW'(1);
                if (w_rd) rptr_q <= rptr_q + AW'(1);
            end
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wptr_q] <= bus.wdata_i;
    end

    generate
        if (RD_LATENCY == 0) begin : g_show_ahead
            assign bus.rdata_o  = w_empty ? '0 : mem_q[rptr_q];
            assign bus.rvalid_o = ~w_empty;
        end else begin : g_registered
            logic [DATA_W-1:0] rdata_q;
            logic              rvalid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (w_rd) begin
                    rdata_q  <= mem_q[rptr_q];
                    rvalid_q <= 1'b1;
                end else begin
                    rvalid_q <= 1'b0;
                end
            end

            assign bus.rdata_o  = rdata_q;
            assign bus.rvalid_o = rvalid_q;
        end
    endgenerate

    assign bus.empty_o        = w_empty;
    assign bus.full_o         = w_full;
    assign bus.almost_empty_o = (count_q <= c_ae);
    assign bus.almost_full_o  = (count_q >= c_af);
    assign bus.used_slots_o   = count_q;
    assign bus.free_slots_o   = c_depth - count_q;
    assign bus.hwm_o          = hwm_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.underflow_o    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_nx_fifo_param.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_nx_fifo_param                                                            |
// | Directed bench: show-ahead instance plus a registered-read instance.        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_nx_fifo_param;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    nx_fifo_param_if #(.DATA_W(64), .DEPTH(16)) bus0 ();
    nx_fifo_param_if #(.DATA_W(64), .DEPTH(16)) bus1 ();

    nx_fifo_param #(.DATA_W(64), .DEPTH(16), .RD_LATENCY(0), .AF_THRESH(12), .AE_THRESH(2))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    nx_fifo_param #(.DATA_W(64), .DEPTH(16), .RD_LATENCY(1), .AF_THRESH(12), .AE_THRESH(2))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus0.clear_i = 0; bus0.wen_i = 0; bus0.ren_i = 0; bus0.wdata_i = '0;
        bus1.clear_i = 0; bus1.wen_i = 0; bus1.ren_i = 0; bus1.wdata_i = '0;
    endtask

    task automatic clear0();
        bus0.clear_i = 1; tick(); bus0.clear_i = 0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1;
        #12;
        n_tests++; if (bus0.empty_o !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", bus0.empty_o); end
        n_tests++; if (bus0.full_o !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b want 0", bus0.full_o); end
        n_tests++; if (bus0.almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL rst_ae got %b want 1", bus0.almost_empty_o); end
        n_tests++; if (bus0.almost_full_o !== 1'b0) begin n_fail++; $display("FAIL rst_af got %b want 0", bus0.almost_full_o); end
        n_tests++; if (bus0.used_slots_o !== 5'd0) begin n_fail++; $display("FAIL rst_used got %0d want 0", bus0.used_slots_o); end
        n_tests++; if (bus0.free_slots_o !== 5'd16) begin n_fail++; $display("FAIL rst_free got %0d want 16", bus0.free_slots_o); end
        n_tests++; if (bus0.hwm_o !== 5'd0) begin n_fail++; $display("FAIL rst_hwm got %0d want 0", bus0.hwm_o); end
        n_tests++; if ({bus0.overflow_o, bus0.underflow_o} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b want 00", {bus0.overflow_o, bus0.underflow_o}); end
        n_tests++; if (bus0.rdata_o !== 64'd0 || bus0.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rd0 got %h/%b want 0/0", bus0.rdata_o, bus0.rvalid_o); end
        n_tests++; if (bus1.rdata_o !== 64'd0 || bus1.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rd1 got %h/%b want 0/0", bus1.rdata_o, bus1.rvalid_o); end
        @(posedge clk); #1;
        rst = 0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            bus0.wen_i = 1; bus0.wdata_i = 64'(i);
            tick();
            n_tests++; if (bus0.used_slots_o !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_used[%0d] got %0d want %0d", i, bus0.used_slots_o, i + 1); end
            n_tests++; if (bus0.almost_full_o !== (i >= 11)) begin n_fail++; $display("FAIL fill_af[%0d] got %b want %b", i, bus0.almost_full_o, i >= 11); end
            n_tests++; if (bus0.full_o !== (i == 15)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, bus0.full_o, i == 15); end
            n_tests++; if (bus0.hwm_o !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_hwm[%0d] got %0d want %0d", i, bus0.hwm_o, i + 1); end
        end
        n_tests++; if (bus0.free_slots_o !== 5'd0) begin n_fail++; $display("FAIL fill_free got %0d want 0", bus0.free_slots_o); end
        bus0.wdata_i = 64'hDEAD;
        tick();
        n_tests++; if (bus0.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_first got %b want 1", bus0.overflow_o); end
        tick();
        bus0.wen_i = 0;
        n_tests++; if (bus0.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_b2b got %b want 1", bus0.overflow_o); end
        n_tests++; if (bus0.used_slots_o !== 5'd16) begin n_fail++; $display("FAIL ovf_used got %0d want 16", bus0.used_slots_o); end
        tick();
        n_tests++; if (bus0.overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_drop got %b want 0", bus0.overflow_o); end
        n_tests++; if (bus0.hwm_o !== 5'd16) begin n_fail++; $display("FAIL ovf_hwm got %0d want 16", bus0.hwm_o); end
    endtask

    task automatic test_read();
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (bus0.rdata_o !== 64'(i) || bus0.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rd_data[%0d] got %h/%b want %h/1", i, bus0.rdata_o, bus0.rvalid_o, i); end
            bus0.ren_i = 1;
            tick();
            n_tests++; if (bus0.used_slots_o !== 5'(15 - i)) begin n_fail++; $display("FAIL rd_used[%0d] got %0d want %0d", i, bus0.used_slots_o, 15 - i); end
            n_tests++; if (bus0.almost_empty_o !== (i >= 13)) begin n_fail++; $display("FAIL rd_ae[%0d] got %b want %b", i, bus0.almost_empty_o, i >= 13); end
            n_tests++; if (bus0.empty_o !== (i == 15)) begin n_fail++; $display("FAIL rd_empty[%0d] got %b want %b", i, bus0.empty_o, i == 15); end
        end
        tick();
        bus0.ren_i = 0;
        n_tests++; if (bus0.underflow_o !== 1'b1) begin n_fail++; $display("FAIL unf_pulse got %b want 1", bus0.underflow_o); end
        n_tests++; if (bus0.rdata_o !== 64'd0 || bus0.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL unf_rdata got %h/%b want 0/0", bus0.rdata_o, bus0.rvalid_o); end
        tick();
        n_tests++; if (bus0.underflow_o !== 1'b0) begin n_fail++; $display("FAIL unf_drop got %b want 0", bus0.underflow_o); end
        n_tests++; if (bus0.hwm_o !== 5'd16) begin n_fail++; $display("FAIL rd_hwm got %0d want 16", bus0.hwm_o); end
    endtask

    task automatic test_simultaneous();
        logic [63:0] exp;
        clear0();
        n_tests++; if (bus0.hwm_o !== 5'd0) begin n_fail++; $display("FAIL clr_hwm got %0d want 0", bus0.hwm_o); end
        for (int i = 0; i < 16; i++) begin
            bus0.wen_i = 1; bus0.wdata_i = 64'h100 + 64'(i);
            tick();
        end
        // Only the first wen+ren sees full; the rest see 15 and both are accepted
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (bus0.rdata_o !== 64'h100 + 64'(k)) begin n_fail++; $display("FAIL sim_head[%0d] got %h want %h", k, bus0.rdata_o, 64'h100 + 64'(k)); end
            bus0.wen_i = 1; bus0.ren_i = 1; bus0.wdata_i = 64'h200 + 64'(k);
            tick();
            n_tests++; if (bus0.overflow_o !== (k == 0)) begin n_fail++; $display("FAIL sim_ovf[%0d] got %b want %b", k, bus0.overflow_o, k == 0); end
            n_tests++; if (bus0.used_slots_o !== 5'd15) begin n_fail++; $display("FAIL sim_used[%0d] got %0d want 15", k, bus0.used_slots_o); end
        end
        bus0.wen_i = 0; bus0.ren_i = 0;
        for (int j = 0; j < 15; j++) begin
            exp = (j < 11) ? 64'h105 + 64'(j) : 64'h201 + 64'(j - 11);
            n_tests++; if (bus0.rdata_o !== exp) begin n_fail++; $display("FAIL sim_drain[%0d] got %h want %h", j, bus0.rdata_o, exp); end
            bus0.ren_i = 1;
            tick();
        end
        bus0.wen_i = 1; bus0.ren_i = 1; bus0.wdata_i = 64'h3C;
        tick();
        bus0.wen_i = 0; bus0.ren_i = 0;
        n_tests++; if (bus0.used_slots_o !== 5'd1) begin n_fail++; $display("FAIL emp_used got %0d want 1", bus0.used_slots_o); end
        n_tests++; if (bus0.underflow_o !== 1'b1) begin n_fail++; $display("FAIL emp_unf got %b want 1", bus0.underflow_o); end
        n_tests++; if (bus0.rdata_o !== 64'h3C) begin n_fail++; $display("FAIL emp_rdata got %h want 3c", bus0.rdata_o); end
    endtask

    task automatic test_stream();
        clear0();
        for (int i = 0; i < 3; i++) begin
            bus0.wen_i = 1; bus0.wdata_i = 64'h1000 + 64'(i);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            n_tests++; if (bus0.rdata_o !== 64'h1000 + 64'(k)) begin n_fail++; $display("FAIL str_data[%0d] got %h want %h", k, bus0.rdata_o, 64'h1000 + 64'(k)); end
            bus0.wen_i = 1; bus0.ren_i = 1; bus0.wdata_i = 64'h1000 + 64'(k + 3);
            tick();
            n_tests++; if (bus0.used_slots_o !== 5'd3) begin n_fail++; $display("FAIL str_used[%0d] got %0d want 3", k, bus0.used_slots_o); end
        end
        bus0.wen_i = 0; bus0.ren_i = 0;
        n_tests++; if (bus0.hwm_o !== 5'd3) begin n_fail++; $display("FAIL str_hwm got %0d want 3", bus0.hwm_o); end
        n_tests++; if (bus0.rdata_o !== 64'h1028) begin n_fail++; $display("FAIL str_tail got %h want 1028", bus0.rdata_o); end
    endtask

    task automatic test_latency1();
        bus1.wen_i = 1; bus1.wdata_i = 64'hA5;
        tick();
        bus1.wen_i = 0;
        n_tests++; if (bus1.rvalid_o !== 1'b0 || bus1.used_slots_o !== 5'd1) begin n_fail++; $display("FAIL l1_wr got %b/%0d want 0/1", bus1.rvalid_o, bus1.used_slots_o); end
        bus1.ren_i = 1;
        tick();
        bus1.ren_i = 0;
        n_tests++; if (bus1.rvalid_o !== 1'b1 || bus1.rdata_o !== 64'hA5) begin n_fail++; $display("FAIL l1_rd got %b/%h want 1/a5", bus1.rvalid_o, bus1.rdata_o); end
        tick();
        n_tests++; if (bus1.rvalid_o !== 1'b0 || bus1.rdata_o !== 64'hA5) begin n_fail++; $display("FAIL l1_hold got %b/%h want 0/a5", bus1.rvalid_o, bus1.rdata_o); end
        bus1.ren_i = 1;
        tick();
        bus1.ren_i = 0;
        n_tests++; if (bus1.rvalid_o !== 1'b0 || bus1.underflow_o !== 1'b1) begin n_fail++; $display("FAIL l1_unf got %b/%b want 0/1", bus1.rvalid_o, bus1.underflow_o); end
    endtask

    task automatic test_clear_rst();
        clear0();
        for (int i = 0; i < 16; i++) begin
            bus0.wen_i = 1; bus0.wdata_i = 64'h50 + 64'(i);
            tick();
            if (i == 6) begin
                n_tests++; if (bus0.used_slots_o !== 5'd7) begin n_fail++; $display("FAIL clr_fill got %0d want 7", bus0.used_slots_o); end
            end
        end
        // Clear while full with both requests: nothing may leak through
        bus0.clear_i = 1; bus0.wen_i = 1; bus0.ren_i = 1;
        tick();
        bus0.clear_i = 0; bus0.wen_i = 0;
        n_tests++; if (bus0.used_slots_o !== 5'd0 || bus0.hwm_o !== 5'd0 || bus0.empty_o !== 1'b1) begin n_fail++; $display("FAIL clr_state got %0d/%0d/%b want 0/0/1", bus0.used_slots_o, bus0.hwm_o, bus0.empty_o); end
        n_tests++; if ({bus0.overflow_o, bus0.underflow_o} !== 2'b00) begin n_fail++; $display("FAIL clr_flags got %b want 00", {bus0.overflow_o, bus0.underflow_o}); end
        bus0.clear_i = 1;
        tick();
        bus0.clear_i = 0; bus0.ren_i = 0;
        n_tests++; if (bus0.underflow_o !== 1'b0 || bus0.used_slots_o !== 5'd0) begin n_fail++; $display("FAIL clr_unf got %b/%0d want 0/0", bus0.underflow_o, bus0.used_slots_o); end
        bus0.wen_i = 1; bus0.wdata_i = 64'h99;
        bus1.wen_i = 1; bus1.wdata_i = 64'h77;
        tick();
        bus1.wen_i = 0; bus1.ren_i = 1;
        tick();
        bus1.ren_i = 0;
        n_tests++; if (bus1.rvalid_o !== 1'b1 || bus0.used_slots_o !== 5'd2) begin n_fail++; $display("FAIL pre_rst got %b/%0d want 1/2", bus1.rvalid_o, bus0.used_slots_o); end
        #2;
        rst = 1;
        #1;
        n_tests++; if (bus0.used_slots_o !== 5'd0 || bus0.empty_o !== 1'b1 || bus0.free_slots_o !== 5'd16) begin n_fail++; $display("FAIL arst_cnt got %0d/%b/%0d want 0/1/16", bus0.used_slots_o, bus0.empty_o, bus0.free_slots_o); end
        n_tests++; if (bus0.hwm_o !== 5'd0 || bus0.rdata_o !== 64'd0 || bus0.almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL arst_misc got %0d/%h/%b want 0/0/1", bus0.hwm_o, bus0.rdata_o, bus0.almost_empty_o); end
        n_tests++; if (bus1.rvalid_o !== 1'b0 || bus1.rdata_o !== 64'd0) begin n_fail++; $display("FAIL arst_rd1 got %b/%h want 0/0", bus1.rvalid_o, bus1.rdata_o); end
        bus0.wen_i = 0;
        @(posedge clk); #1;
        rst = 0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_read();
        test_simultaneous();
        test_stream();
        test_latency1();
        test_clear_rst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
